// File: rtl/soc_sram_ctl.sv
// 32-bit bus responder backed by a 16-bit asynchronous SRAM.
// Each word access runs as two halfword SRAM cycles (low half first) with WAIT extra cycles per phase.
module soc_sram_ctl #(
  parameter int unsigned AW   = 18,
  parameter int unsigned WAIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   addr,
  input  logic          rw,
  input  logic [31:0]   dwrite,
  output logic [31:0]   dread,
  input  logic          valid,
  output logic          ready,
  output logic [AW-1:0] sram_addr,
  output logic [15:0]   sram_dq_o,
  input  logic [15:0]   sram_dq_i,
  output logic          sram_dq_oe,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, ACC, HOLD, RESP} state_t;

  state_t          state, state_nx;
  logic [AW:2]     req_addr, req_addr_nx;
  logic            req_rw, req_rw_nx;
  logic [31:0]     req_wdata, req_wdata_nx;
  logic            half, half_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [15:0]     lo, lo_nx, hi, hi_nx;
  logic [31:0]     dread_nx;
  logic            ready_nx;
  logic [AW-1:0]   sram_addr_nx;
  logic [15:0]     sram_dq_o_nx;
  logic            sram_dq_oe_nx, sram_ce_n_nx, sram_oe_n_nx, sram_we_n_nx;

  // Byte-lane bits and bits above the SRAM window alias.
  logic unused_addr;
  assign unused_addr = ^{addr[1:0], addr[31:AW+1]};

  always_comb begin
    state_nx     = state;
    req_addr_nx  = req_addr;
    req_rw_nx    = req_rw;
    req_wdata_nx = req_wdata;
    half_nx      = half;
    cnt_nx       = cnt;
    lo_nx        = lo;
    hi_nx        = hi;
    dread_nx     = dread;

    case (state)
      IDLE: begin
        if (valid) begin
          req_addr_nx  = addr[AW:2];
          req_rw_nx    = rw;
          req_wdata_nx = dwrite;
          half_nx      = 1'b0;
          cnt_nx       = CW'(WAIT);
          state_nx     = ACC;
        end
      end
      ACC: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
        end else begin
          if (!req_rw) begin
            if (half) hi_nx = sram_dq_i;
            else      lo_nx = sram_dq_i;
          end
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (!half) begin
          half_nx  = 1'b1;
          cnt_nx   = CW'(WAIT);
          state_nx = ACC;
        end else begin
          if (!req_rw) dread_nx = {hi, lo};
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Pad controls are decoded from the upcoming state so they leave a flop.
    sram_ce_n_nx  = !(state_nx == ACC || state_nx == HOLD);
    sram_oe_n_nx  = !(state_nx == ACC && !req_rw_nx);
    sram_we_n_nx  = !(state_nx == ACC && req_rw_nx);
    sram_dq_oe_nx = (state_nx == ACC || state_nx == HOLD) && req_rw_nx;
    ready_nx      = (state_nx == RESP);
    sram_addr_nx  = sram_addr;
    sram_dq_o_nx  = sram_dq_o;
    if (state_nx == ACC) begin
      sram_addr_nx = {req_addr_nx, half_nx};
      if (req_rw_nx) sram_dq_o_nx = half_nx ? req_wdata_nx[31:16] : req_wdata_nx[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_rw     <= 1'b0;
      req_wdata  <= '0;
      half       <= 1'b0;
      cnt        <= '0;
      lo         <= '0;
      hi         <= '0;
      dread      <= '0;
      ready      <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      state      <= state_nx;
      req_addr   <= req_addr_nx;
      req_rw     <= req_rw_nx;
      req_wdata  <= req_wdata_nx;
      half       <= half_nx;
      cnt        <= cnt_nx;
      lo         <= lo_nx;
      hi         <= hi_nx;
      dread      <= dread_nx;
      ready      <= ready_nx;
      sram_addr  <= sram_addr_nx;
      sram_dq_o  <= sram_dq_o_nx;
      sram_dq_oe <= sram_dq_oe_nx;
      sram_ce_n  <= sram_ce_n_nx;
      sram_oe_n  <= sram_oe_n_nx;
      sram_we_n  <= sram_we_n_nx;
    end
  end

endmodule

// File: tb/tb_soc_sram_ctl.sv
// Directed bench for soc_sram_ctl: a WAIT=2 instance (a_*) and a WAIT=0 instance (b_*),
// each attached to a small behavioural SRAM.
module tb_soc_sram_ctl;

  localparam int unsigned AW = 18;

  logic clk;
  logic reset;

  logic [31:0]   a_addr, a_dwrite, a_dread;
  logic          a_rw, a_valid, a_ready;
  logic [AW-1:0] a_sram_addr;
  logic [15:0]   a_dq_o, a_dq_i;
  logic          a_dq_oe, a_ce_n, a_oe_n, a_we_n;

  logic [31:0]   b_addr, b_dwrite, b_dread;
  logic          b_rw, b_valid, b_ready;
  logic [AW-1:0] b_sram_addr;
  logic [15:0]   b_dq_o, b_dq_i;
  logic          b_dq_oe, b_ce_n, b_oe_n, b_we_n;

  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];

  int total;
  int bad;

  soc_sram_ctl #(.AW(AW), .WAIT(2)) u_a (
    .clk(clk), .reset(reset), .addr(a_addr), .rw(a_rw), .dwrite(a_dwrite),
    .dread(a_dread), .valid(a_valid), .ready(a_ready), .sram_addr(a_sram_addr),
    .sram_dq_o(a_dq_o), .sram_dq_i(a_dq_i), .sram_dq_oe(a_dq_oe),
    .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n)
  );

  soc_sram_ctl #(.AW(AW), .WAIT(0)) u_b (
    .clk(clk), .reset(reset), .addr(b_addr), .rw(b_rw), .dwrite(b_dwrite),
    .dread(b_dread), .valid(b_valid), .ready(b_ready), .sram_addr(b_sram_addr),
    .sram_dq_o(b_dq_o), .sram_dq_i(b_dq_i), .sram_dq_oe(b_dq_oe),
    .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAMs: combinational read while selected, write on clock while WE is low.
  assign a_dq_i = (!a_ce_n && !a_oe_n) ? mem_a[a_sram_addr[7:0]] : 16'h0000;
  assign b_dq_i = (!b_ce_n && !b_oe_n) ? mem_b[b_sram_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!a_ce_n && !a_we_n && a_dq_oe) mem_a[a_sram_addr[7:0]] <= a_dq_o;
    if (!b_ce_n && !b_we_n && b_dq_oe) mem_b[b_sram_addr[7:0]] <= b_dq_o;
  end

  task automatic test_reset;
    reset = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", a_ready); end
    total++; if (a_dread !== 32'h0) begin bad++; $display("FAIL reset_dread got=%h want=00000000", a_dread); end
    total++; if ({a_ce_n, a_oe_n, a_we_n} !== 3'b111) begin bad++; $display("FAIL reset_strobes got=%b want=111", {a_ce_n, a_oe_n, a_we_n}); end
    total++; if ({a_dq_oe, a_sram_addr, a_dq_o} !== '0) begin bad++; $display("FAIL reset_pad got oe=%b addr=%h dq=%h want 0", a_dq_oe, a_sram_addr, a_dq_o); end
    total++; if ({b_ready, b_dread, b_ce_n, b_oe_n, b_we_n, b_dq_oe} !== {1'b0, 32'h0, 3'b111, 1'b0}) begin bad++; $display("FAIL reset_b got rdy=%b dread=%h strobes=%b%b%b oe=%b", b_ready, b_dread, b_ce_n, b_oe_n, b_we_n, b_dq_oe); end
    reset = 1'b0;
  endtask

  task automatic test_write;
    logic [11:0] we_h, rdy_h, dqoe_h;
    logic [AW-1:0] addr0, addr1;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 32'h10; a_rw = 1'b1; a_dwrite = 32'hDEADBEEF;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      we_h[i] = a_we_n; rdy_h[i] = a_ready; dqoe_h[i] = a_dq_oe;
      if (i == 0) addr0 = a_sram_addr;
      if (i == 4) addr1 = a_sram_addr;
      if (a_ready) a_valid = 1'b0;
    end
    total++; if (we_h !== 12'hF88) begin bad++; $display("FAIL write_we_pattern got=%h want=f88", we_h); end
    total++; if (rdy_h !== 12'h100) begin bad++; $display("FAIL write_ready_timing got=%h want=100", rdy_h); end
    total++; if (dqoe_h !== 12'h0FF) begin bad++; $display("FAIL write_dq_oe got=%h want=0ff", dqoe_h); end
    total++; if (addr0 !== 18'd8 || addr1 !== 18'd9) begin bad++; $display("FAIL write_halfaddr got=%0d,%0d want=8,9", addr0, addr1); end
    total++; if (mem_a[8] !== 16'hBEEF || mem_a[9] !== 16'hDEAD) begin bad++; $display("FAIL write_mem got=%h_%h want=dead_beef", mem_a[9], mem_a[8]); end
  endtask

  task automatic test_read;
    logic [11:0] we_h, oe_h, rdy_h, dqoe_h;
    logic        both_low;
    logic [31:0] rd;
    both_low = 1'b0; rd = '0;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 32'h10; a_rw = 1'b0; a_dwrite = 32'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      we_h[i] = a_we_n; oe_h[i] = a_oe_n; rdy_h[i] = a_ready; dqoe_h[i] = a_dq_oe;
      if (!a_we_n && !a_oe_n) both_low = 1'b1;
      if (a_ready) begin rd = a_dread; a_valid = 1'b0; end
    end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL read_data got=%h want=deadbeef", rd); end
    total++; if (oe_h !== 12'hF88) begin bad++; $display("FAIL read_oe_pattern got=%h want=f88", oe_h); end
    total++; if (we_h !== 12'hFFF || dqoe_h !== 12'h000) begin bad++; $display("FAIL read_no_drive got we=%h dqoe=%h want fff/000", we_h, dqoe_h); end
    total++; if (rdy_h !== 12'h100) begin bad++; $display("FAIL read_ready_timing got=%h want=100", rdy_h); end
    total++; if (both_low !== 1'b0) begin bad++; $display("FAIL read_oe_we_overlap got=%b want=0", both_low); end
  endtask

  task automatic test_wait0_read;
    logic [7:0]  oe_h, rdy_h;
    logic [31:0] rd4;
    mem_b[0] = 16'h1234; mem_b[1] = 16'hABCD;
    @(negedge clk);
    b_valid = 1'b1; b_addr = 32'h3; b_rw = 1'b0; b_dwrite = 32'h0;
    rd4 = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      oe_h[i] = b_oe_n; rdy_h[i] = b_ready;
      if (i == 4) rd4 = b_dread;
      if (b_ready) b_valid = 1'b0;
    end
    total++; if (rdy_h !== 8'h10) begin bad++; $display("FAIL w0_ready_timing got=%h want=10", rdy_h); end
    total++; if (rd4 !== 32'hABCD1234) begin bad++; $display("FAIL w0_read_data got=%h want=abcd1234", rd4); end
    total++; if (oe_h !== 8'hFA) begin bad++; $display("FAIL w0_oe_pattern got=%h want=fa", oe_h); end
  endtask

  task automatic test_back_to_back;
    logic [21:0] rdy_h;
    logic        switched;
    logic [31:0] rd_first;
    switched = 1'b0; rd_first = '0;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 32'h10; a_rw = 1'b0; a_dwrite = 32'h0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rdy_h[i] = a_ready;
      if (a_ready && !switched) begin
        rd_first = a_dread; switched = 1'b1;
        a_addr = 32'h20; a_rw = 1'b1; a_dwrite = 32'hCAFEF00D;
      end else if (a_ready) begin
        a_valid = 1'b0;
      end
    end
    total++; if (rdy_h !== 22'h040100) begin bad++; $display("FAIL b2b_ready_spacing got=%h want=040100", rdy_h); end
    total++; if (rd_first !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_first_read got=%h want=deadbeef", rd_first); end
    total++; if (mem_a[16] !== 16'hF00D || mem_a[17] !== 16'hCAFE) begin bad++; $display("FAIL b2b_write_mem got=%h_%h want=cafe_f00d", mem_a[17], mem_a[16]); end
    total++; if (a_dread !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_dread_after_write got=%h want=deadbeef", a_dread); end
  endtask

  task automatic test_reset_mid;
    logic        rdy_seen;
    logic [11:0] rdy_h;
    logic [31:0] rd;
    rdy_seen = 1'b0; rd = '0;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 32'h10; a_rw = 1'b1; a_dwrite = 32'h55667788;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_ready) rdy_seen = 1'b1;
    end
    total++; if (a_we_n !== 1'b0 || a_sram_addr !== 18'd9) begin bad++; $display("FAIL rst_in_acc1 got we_n=%b addr=%0d want 0/9", a_we_n, a_sram_addr); end
    reset = 1'b1;
    #1;
    total++; if ({a_ce_n, a_oe_n, a_we_n, a_dq_oe, a_ready} !== 5'b11100) begin bad++; $display("FAIL rst_async_outputs got=%b want=11100", {a_ce_n, a_oe_n, a_we_n, a_dq_oe, a_ready}); end
    a_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (a_ready) rdy_seen = 1'b1;
    end
    reset = 1'b0;
    total++; if (rdy_seen !== 1'b0) begin bad++; $display("FAIL rst_no_ready got=%b want=0", rdy_seen); end
    @(negedge clk);
    a_valid = 1'b1; a_addr = 32'h10; a_rw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rdy_h[i] = a_ready;
      if (a_ready) begin rd = a_dread; a_valid = 1'b0; end
    end
    total++; if (rdy_h !== 12'h100) begin bad++; $display("FAIL rst_after_ready got=%h want=100", rdy_h); end
    total++; if (rd !== 32'hDEAD7788) begin bad++; $display("FAIL rst_after_read got=%h want=dead7788", rd); end
  endtask

  task automatic test_read_after_write;
    logic        changed;
    logic [31:0] rd7, rd8;
    changed = 1'b0; rd7 = '0; rd8 = '0;
    @(negedge clk);
    a_valid = 1'b1; a_addr = 32'h30; a_rw = 1'b1; a_dwrite = 32'h11112222;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_dread !== 32'hDEAD7788) changed = 1'b1;
      if (a_ready) a_valid = 1'b0;
    end
    total++; if (changed !== 1'b0) begin bad++; $display("FAIL raw_dread_stable got=%b want=0", changed); end
    total++; if (mem_a[24] !== 16'h2222 || mem_a[25] !== 16'h1111) begin bad++; $display("FAIL raw_write_mem got=%h_%h want=1111_2222", mem_a[25], mem_a[24]); end
    @(negedge clk);
    a_valid = 1'b1; a_addr = 32'h20; a_rw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 7) rd7 = a_dread;
      if (i == 8) rd8 = a_dread;
      if (a_ready) a_valid = 1'b0;
    end
    total++; if (rd7 !== 32'hDEAD7788) begin bad++; $display("FAIL raw_dread_before_resp got=%h want=dead7788", rd7); end
    total++; if (rd8 !== 32'hCAFEF00D) begin bad++; $display("FAIL raw_new_read got=%h want=cafef00d", rd8); end
  endtask

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 256; i++) begin mem_a[i] = 16'h0; mem_b[i] = 16'h0; end
    a_addr = '0; a_dwrite = '0; a_rw = 1'b0; a_valid = 1'b0;
    b_addr = '0; b_dwrite = '0; b_rw = 1'b0; b_valid = 1'b0;
    test_reset;
    test_write;
    test_read;
    test_wait0_read;
    test_back_to_back;
    test_reset_mid;
    test_read_after_write;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
